// File: rtl/div_sequencer_if.sv
// Handshake bundle between the EX stage and the divide sequencer.
// The pipeline side drives the operation request; the sequencer answers with busy/stall/done/result.
interface div_sequencer_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [4:0]      alu_ctl;
   logic [XLEN-1:0] src1;
   logic [XLEN-1:0] src2;
   logic            flush;
   logic            busy;
   logic            stall;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (
      output start, alu_ctl, src1, src2, flush,
      input  busy, stall, done, result
   );

   modport slave (
      input  start, alu_ctl, src1, src2, flush,
      output busy, stall, done, result
   );
endinterface

// File: rtl/div_sequencer.sv
// RV32M div/divu/rem/remu sequencer: radix-2 restoring divider, one quotient bit per cycle.
// Latency accept->done is XLEN+1 cycles (1 for divide-by-zero/overflow); stalls upstream while computing.
module div_sequencer #(
   parameter int XLEN = 32
) (
   input logic           clk,
   input logic           rst,
   div_sequencer_if.slave bus
);
   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;

   // dvd holds the dividend and collects quotient bits as it shifts out.
   logic [XLEN-1:0] dvd;
   logic [XLEN-1:0] rem;
   logic [XLEN-1:0] dsr;
   logic [XLEN-1:0] res_q;
   logic [CW-1:0]   cnt;
   logic            q_neg;
   logic            r_neg;
   logic            op_rem;

   logic            is_div_op;
   logic            is_signed;
   logic            is_rem_op;
   logic            accept;
   logic            div_zero;
   logic            sgn_ovf;
   logic            special;
   logic [XLEN-1:0] mag1;
   logic [XLEN-1:0] mag2;
   logic [XLEN:0]   rem_sh;
   logic [XLEN:0]   diff;
   logic            q_bit;
   logic [XLEN-1:0] fin_val;

   always_comb begin
      is_div_op = bus.alu_ctl inside {5'b00110, 5'b00111, 5'b01000, 5'b01001};
      is_signed = (bus.alu_ctl == 5'b00110) || (bus.alu_ctl == 5'b01000);
      is_rem_op = (bus.alu_ctl == 5'b01000) || (bus.alu_ctl == 5'b01001);
      accept    = (state == IDLE) && bus.start && is_div_op && !bus.flush;
      div_zero  = (bus.src2 == '0);
      sgn_ovf   = is_signed && (bus.src1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.src2 == '1);
      special   = div_zero || sgn_ovf;
      mag1      = (is_signed && bus.src1[XLEN-1]) ? -bus.src1 : bus.src1;
      mag2      = (is_signed && bus.src2[XLEN-1]) ? -bus.src2 : bus.src2;
      // One extra bit on the trial subtract keeps the borrow as the compare result.
      rem_sh    = {rem, dvd[XLEN-1]};
      diff      = rem_sh - {1'b0, dsr};
      q_bit     = ~diff[XLEN];
      fin_val   = op_rem ? (r_neg ? -rem : rem) : (q_neg ? -dvd : dvd);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = special ? FIN : CALC;
         CALC: if (cnt == '0) state_nxt = FIN;
         FIN:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (bus.flush) state_nxt = IDLE;

      bus.busy   = (state == CALC) || (state == FIN);
      bus.stall  = accept || (state == CALC);
      bus.done   = (state == FIN) && !bus.flush;
      bus.result = bus.done ? fin_val : res_q;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dvd    <= '0;
         rem    <= '0;
         dsr    <= '0;
         res_q  <= '0;
         cnt    <= '0;
         q_neg  <= 1'b0;
         r_neg  <= 1'b0;
         op_rem <= 1'b0;
      end else begin
         if (accept) begin
            dsr    <= mag2;
            op_rem <= is_rem_op;
            cnt    <= CW'(XLEN - 1);
            // Special cases preload the final magnitudes so FIN needs no extra muxing.
            if (div_zero) begin
               dvd   <= '1;
               rem   <= bus.src1;
               q_neg <= 1'b0;
               r_neg <= 1'b0;
            end else if (sgn_ovf) begin
               dvd   <= bus.src1;
               rem   <= '0;
               q_neg <= 1'b0;
               r_neg <= 1'b0;
            end else begin
               dvd   <= mag1;
               rem   <= '0;
               q_neg <= is_signed && (bus.src1[XLEN-1] ^ bus.src2[XLEN-1]);
               r_neg <= is_signed && bus.src1[XLEN-1];
            end
         end else if ((state == CALC) && !bus.flush) begin
            dvd <= {dvd[XLEN-2:0], q_bit};
            rem <= q_bit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
            if (cnt != '0) cnt <= cnt - 1'b1;
         end
         if (bus.done) res_q <= fin_val;
      end
   end
endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: directed literal cases plus random traffic checked every cycle against a timing/result model.
module tb_div_sequencer;
   localparam int XLEN = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   div_sequencer_if #(.XLEN(XLEN)) bus();
   div_sequencer #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // Model: an op in flight counts down cycles to its done cycle.
   bit          m_active = 1'b0;
   int          m_left = 0;
   logic [31:0] m_res = '0;
   logic [31:0] m_held = '0;
   bit          m_acc;
   bit          m_done;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit valid_op(input logic [4:0] op);
      return (op == 5'd6) || (op == 5'd7) || (op == 5'd8) || (op == 5'd9);
   endfunction

   function automatic bit is_special(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      return (b == 32'h0) || (((op == 5'd6) || (op == 5'd8)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
   endfunction

   function automatic logic [31:0] ref_div(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      logic signed [31:0] sr;
      sa = a;
      sb = b;
      case (op)
         5'd6: begin
            if (b == 32'h0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            sr = sa / sb;
            return sr;
         end
         5'd7: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
         5'd8: begin
            if (b == 32'h0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            sr = sa % sb;
            return sr;
         end
         default: return (b == 32'h0) ? a : a % b;
      endcase
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         m_acc  = !m_active && bus.start && valid_op(bus.alu_ctl) && !bus.flush;
         m_done = m_active && (m_left == 0) && !bus.flush;
         check32("busy",   32'(bus.busy),  32'(m_active));
         check32("stall",  32'(bus.stall), 32'(m_acc || (m_active && m_left > 0)));
         check32("done",   32'(bus.done),  32'(m_done));
         check32("result", bus.result, m_done ? m_res : m_held);
         if (rst) begin
            m_active = 1'b0;
            m_held   = '0;
         end else if (bus.flush) begin
            m_active = 1'b0;
         end else if (m_active) begin
            if (m_left == 0) begin
               m_active = 1'b0;
               m_held   = m_res;
            end else begin
               m_left--;
            end
         end else if (m_acc) begin
            m_active = 1'b1;
            m_left   = is_special(bus.alu_ctl, bus.src1, bus.src2) ? 0 : XLEN;
            m_res    = ref_div(bus.alu_ctl, bus.src1, bus.src2);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issues one op in the current cycle and measures cycles until done.
   task automatic do_op(input string name, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
      int n;
      bus.start   = 1'b1;
      bus.alu_ctl = op;
      bus.src1    = a;
      bus.src2    = b;
      step();
      bus.start = 1'b0;
      bus.src1  = $urandom;
      bus.src2  = $urandom;
      n = 1;
      while (!bus.done && n < 64) begin
         step();
         n++;
      end
      check32({name, " latency"}, 32'(n), 32'(lat));
      check32({name, " result"}, bus.result, exp);
      step();
   endtask

   initial begin
      logic [4:0] r;
      bus.start   = 1'b0;
      bus.alu_ctl = 5'd0;
      bus.src1    = '0;
      bus.src2    = '0;
      bus.flush   = 1'b0;
      rst = 1'b1;
      repeat (2) step();
      chk_en = 1'b1;
      step();
      rst = 1'b0;
      check32("reset busy",   32'(bus.busy),  32'd0);
      check32("reset done",   32'(bus.done),  32'd0);
      check32("reset stall",  32'(bus.stall), 32'd0);
      check32("reset result", bus.result,     32'd0);

      do_op("divu 100/7",   5'd7, 32'd100,        32'd7,          32'd14,         33);
      do_op("remu 100/7",   5'd9, 32'd100,        32'd7,          32'd2,          33);
      do_op("div -7/2",     5'd6, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33);
      do_op("rem -7/2",     5'd8, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33);
      do_op("rem 7/-2",     5'd8, 32'd7,          32'hFFFF_FFFE,  32'd1,          33);
      do_op("divu 5/0",     5'd7, 32'd5,          32'd0,          32'hFFFF_FFFF,  1);
      do_op("rem -5/0",     5'd8, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1);
      do_op("div ovf",      5'd6, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1);
      do_op("rem ovf",      5'd8, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1);
      do_op("divu 100/7 b", 5'd7, 32'd100,        32'd7,          32'd14,         33);

      // Flush mid-calculation, then an immediate new op.
      bus.start = 1'b1; bus.alu_ctl = 5'd7; bus.src1 = 32'd100; bus.src2 = 32'd7;
      step();
      bus.start = 1'b0;
      repeat (9) step();
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      check32("flush busy",   32'(bus.busy), 32'd0);
      check32("flush result", bus.result,    32'd14);
      do_op("divu 9/3 after flush", 5'd7, 32'd9, 32'd3, 32'd3, 33);

      // Non-divide opcode is ignored.
      bus.start = 1'b1; bus.alu_ctl = 5'd0; bus.src1 = 32'd50; bus.src2 = 32'd5;
      check32("ignored stall", 32'(bus.stall), 32'd0);
      step();
      bus.start = 1'b0;
      check32("ignored busy", 32'(bus.busy), 32'd0);

      // Reset mid-operation.
      bus.start = 1'b1; bus.alu_ctl = 5'd7; bus.src1 = 32'd100; bus.src2 = 32'd7;
      step();
      bus.start = 1'b0;
      repeat (4) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check32("rst busy",   32'(bus.busy),  32'd0);
      check32("rst done",   32'(bus.done),  32'd0);
      check32("rst stall",  32'(bus.stall), 32'd0);
      check32("rst result", bus.result,     32'd0);

      for (int c = 0; c < 6000; c++) begin
         bus.start = ($urandom % 3 == 0);
         r = 5'($urandom % 10);
         bus.alu_ctl = (r < 8) ? 5'(6 + (r % 4)) : 5'($urandom % 32);
         case ($urandom % 8)
            0: bus.src1 = 32'h8000_0000;
            1: bus.src1 = $urandom % 64;
            default: bus.src1 = $urandom;
         endcase
         case ($urandom % 8)
            0: bus.src2 = 32'h0;
            1: bus.src2 = 32'hFFFF_FFFF;
            2: bus.src2 = 1 + ($urandom % 15);
            default: bus.src2 = $urandom;
         endcase
         bus.flush = ($urandom % 50 == 0);
         rst = ($urandom % 700 == 0);
         step();
      end
      bus.start = 1'b0;
      bus.flush = 1'b0;
      rst = 1'b0;
      repeat (40) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
